vga_scan_reader: RTL

- Read side of the VGA framebuffer that the instruction ROM / CPU `VGA` opcode writes as (color, row, col).
- Generates 640x480@60 Hz timing from the 50 MHz system clock using an internal divide-by-2 pixel enable.
- Scans the framebuffer synchronously, with 1-clock RAM read latency, and drives the RGB and sync pins with all outputs aligned.
- Sits between the dual-port video RAM read port and the board VGA connector.

---
 rtl/vga_scan_reader_pkg.sv | 48 ++++
 rtl/vga_timing_gen.sv | 71 +++++++
 rtl/vga_scan_reader.sv | 84 ++++++++
 3 files changed

// File: rtl/vga_scan_reader_pkg.sv
// Shared definitions for the VGA framebuffer scan-out path.
// Holds the default 640x480@60 timing, the framebuffer geometry, the 3-bit
// colour codes written by the VGA opcode, and the raw per-pixel decode
// record passed from the timing generator to the output pipeline.
package vga_scan_reader_pkg;

  localparam int H_ACTIVE    = 640;
  localparam int H_FP        = 16;
  localparam int H_SYNC      = 96;
  localparam int H_BP        = 48;
  localparam int V_ACTIVE    = 480;
  localparam int V_FP        = 10;
  localparam int V_SYNC      = 2;
  localparam int V_BP        = 33;
  localparam int FB_COL_BITS = 9;
  localparam int FB_ROW_BITS = 8;

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;  // 800
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;  // 525
  // Sync windows are [start, end): hsync 656..751, vsync 490..491.
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  // bit2 = R, bit1 = G, bit0 = B
  localparam logic [2:0] COLOR_BLACK   = 3'b000;
  localparam logic [2:0] COLOR_BLUE    = 3'b001;
  localparam logic [2:0] COLOR_GREEN   = 3'b010;
  localparam logic [2:0] COLOR_CYAN    = 3'b011;
  localparam logic [2:0] COLOR_RED     = 3'b100;
  localparam logic [2:0] COLOR_MAGENTA = 3'b101;
  localparam logic [2:0] COLOR_YELLOW  = 3'b110;
  localparam logic [2:0] COLOR_WHITE   = 3'b111;

  // Raw decode of the current counter position.
  typedef struct packed {
    logic visible;
    logic inwin;    // visible and inside the framebuffer
    logic hsync_n;
    logic vsync_n;
    logic origin;   // counters at (0,0)
  } scan_t;

  localparam scan_t SCAN_RST = '{visible: 1'b0, inwin: 1'b0, hsync_n: 1'b1,
                                 vsync_n: 1'b1, origin: 1'b0};

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel enable, horizontal/vertical counters and raw timing decode.
//   clk, rst  : system clock, async active-high reset
//   pe        : pixel enable, toggles every clk (first high after 1st edge)
//   fb_addr   : {vcount, hcount} truncated to the framebuffer geometry
//   raw       : visible / inwin / hsync_n / vsync_n / origin for the counters
// Assumes COLB and ROWB do not exceed the counter widths.
module vga_timing_gen
  import vga_scan_reader_pkg::*;
#(
  parameter int HACT = H_ACTIVE,
  parameter int HFP  = H_FP,
  parameter int HSW  = H_SYNC,
  parameter int HBP  = H_BP,
  parameter int VACT = V_ACTIVE,
  parameter int VFP  = V_FP,
  parameter int VSW  = V_SYNC,
  parameter int VBP  = V_BP,
  parameter int COLB = FB_COL_BITS,
  parameter int ROWB = FB_ROW_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 pe,
  output logic [ROWB+COLB-1:0] fb_addr,
  output scan_t                raw
);

  localparam int HTOT = HACT + HFP + HSW + HBP;
  localparam int VTOT = VACT + VFP + VSW + VBP;
  localparam int HW   = $clog2(HTOT);
  localparam int VW   = $clog2(VTOT);
  localparam int HS0  = HACT + HFP;
  localparam int HS1  = HS0 + HSW;
  localparam int VS0  = VACT + VFP;
  localparam int VS1  = VS0 + VSW;
  localparam int FBC  = 1 << COLB;
  localparam int FBR  = 1 << ROWB;

  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;

  always_ff @(posedge clk or posedge rst)
    if (rst) pe <= 1'b0;
    else     pe <= ~pe;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hcount <= '0;
      vcount <= '0;
    end else if (pe) begin
      if (hcount == HW'(HTOT - 1)) begin
        hcount <= '0;
        vcount <= (vcount == VW'(VTOT - 1)) ? '0 : vcount + 1'b1;
      end else begin
        hcount <= hcount + 1'b1;
      end
    end

  always_comb begin
    raw         = SCAN_RST;
    raw.visible = (int'(hcount) < HACT) && (int'(vcount) < VACT);
    raw.inwin   = raw.visible && (int'(hcount) < FBC) && (int'(vcount) < FBR);
    raw.hsync_n = !((int'(hcount) >= HS0) && (int'(hcount) < HS1));
    raw.vsync_n = !((int'(vcount) >= VS0) && (int'(vcount) < VS1));
    raw.origin  = (hcount == '0) && (vcount == '0);
  end

  // Outside the window the address still follows the truncated counts.
  assign fb_addr = {vcount[ROWB-1:0], hcount[COLB-1:0]};

endmodule

// File: rtl/vga_scan_reader.sv
// Framebuffer scan-out: drives the video RAM read address and the VGA pins.
//   Clock, Reset  : 50 MHz system clock, async active-high reset
//   oReadAddress  : registered {row, col} read address (updated on pe edges)
//   iReadData     : {R,G,B} from the RAM, valid one Clock after the address
//   oVGA_R/G/B    : pixel colour, black outside the framebuffer / blanking
//   oHSync/oVSync : active-low syncs, aligned with the colour
//   oActive       : displayed pixel is in the visible area
//   oFrameStart   : one-Clock pulse when pixel (0,0) is displayed
// Pipeline: stage 1 registers the address and raw decode on a pe edge, the
// RAM answers on the following (pe=0) edge, stage 2 drives the pins on the
// next pe edge -- every output lags the counters by 4 Clocks.
module vga_scan_reader
  import vga_scan_reader_pkg::*;
#(
  parameter int HACT = H_ACTIVE,
  parameter int HFP  = H_FP,
  parameter int HSW  = H_SYNC,
  parameter int HBP  = H_BP,
  parameter int VACT = V_ACTIVE,
  parameter int VFP  = V_FP,
  parameter int VSW  = V_SYNC,
  parameter int VBP  = V_BP,
  parameter int COLB = FB_COL_BITS,
  parameter int ROWB = FB_ROW_BITS
) (
  input  logic                 Clock,
  input  logic                 Reset,
  output logic [ROWB+COLB-1:0] oReadAddress,
  input  logic [2:0]           iReadData,
  output logic                 oVGA_R,
  output logic                 oVGA_G,
  output logic                 oVGA_B,
  output logic                 oHSync,
  output logic                 oVSync,
  output logic                 oActive,
  output logic                 oFrameStart
);

  localparam int STAGES = 2;

  logic                 pe;
  logic [ROWB+COLB-1:0] fb_addr;
  scan_t                raw, s1;
  logic [STAGES:1]      vld_pipe;  // [n]: stage n holds a real pixel

  vga_timing_gen #(
    .HACT(HACT), .HFP(HFP), .HSW(HSW), .HBP(HBP),
    .VACT(VACT), .VFP(VFP), .VSW(VSW), .VBP(VBP),
    .COLB(COLB), .ROWB(ROWB)
  ) u_tgen (
    .clk     (Clock),
    .rst     (Reset),
    .pe      (pe),
    .fb_addr (fb_addr),
    .raw     (raw)
  );

  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      oReadAddress               <= '0;
      s1                         <= SCAN_RST;
      vld_pipe                   <= '0;
      {oVGA_R, oVGA_G, oVGA_B}   <= COLOR_BLACK;
      oActive                    <= 1'b0;
      oHSync                     <= 1'b1;
      oVSync                     <= 1'b1;
      oFrameStart                <= 1'b0;
    end else begin
      oFrameStart <= 1'b0;
      if (pe) begin
        oReadAddress             <= fb_addr;
        s1                       <= raw;
        vld_pipe                 <= {vld_pipe[STAGES-1:1], 1'b1};
        {oVGA_R, oVGA_G, oVGA_B} <= s1.inwin ? iReadData : COLOR_BLACK;
        oActive                  <= s1.visible;
        oHSync                   <= s1.hsync_n;
        oVSync                   <= s1.vsync_n;
        // The (0,0) that comes straight out of reset is not a frame
        // boundary: only pulse once stage 2 has already shown a pixel.
        oFrameStart              <= s1.origin & vld_pipe[STAGES];
      end
    end

endmodule
